alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Sequential execution controller that sits on the operand side of the 17-bit `alu`. It does the following:
- accepts register-format instructions over a valid/ready handshake;
- reads operands from an 8-entry × 17-bit register file and drives them onto the ALU's `src1_data`/`src2_data`/`opcode`;
- captures `dest_data`/`overflow`, writes the result back, and reports it on a result strobe.

It keeps a sticky overflow flag for the host.

## Interface
Parameters:
- `DATA_W`, 17: operand and result width; must match the ALU.
- `NREGS`, 8: register file depth; the address width is log2(`NREGS`) = 3.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  controller can accept an instruction.
- `in_op`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MULT, 110 LOADI, 111 NOP.
- `in_rd`, `in_rs1`, `in_rs2`  in  3 each  destination and source register indices.
- `in_imm`  in  17  immediate; used only by LOADI.
- `alu_src1`, `alu_src2`  out  17  registered operands driven to the ALU.
- `alu_opcode`  out  3  registered opcode driven to the ALU.
- `alu_dest`  in  17  combinational result from the ALU.
- `alu_ovf`  in  1  combinational overflow from the ALU.
- `res_valid`  out  1  one-cycle result strobe.
- `res_rd`  out  3  register index the result was written to.
- `res_data`  out  17  value written.
- `res_ovf`  out  1  overflow of this instruction.
- `ovf_sticky`  out  1  OR of all `res_ovf` since reset or clear.
- `ovf_clr`  in  1  clears `ovf_sticky`.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  17  combinational read of `regs[dbg_addr]`.

## Operation
- FSM states:
  - `IDLE`: `in_ready`=1.
  - `ISSUE`: `in_ready`=0.
- Handshake:
  - Transfer occurs when `in_valid` && `in_ready`.
  - On transfer, the fields are latched, `alu_src1`=`regs[rs1]`, `alu_src2`=`regs[rs2]` and `alu_opcode`=`in_op`, all registered, and the FSM moves IDLE→ISSUE.
  - `in_valid` asserted while the controller is busy is ignored and must be held by the source.
- In ISSUE, the controller samples the ALU output on the ending edge:
  - ALU ops (000–101): `regs[rd]`←`alu_dest`; `res_ovf`←`alu_ovf`.
  - LOADI: `regs[rd]`←`in_imm` as latched; `res_ovf`=0; the ALU output is ignored.
  - NOP: no register write; `res_valid` still pulses with `res_data`=0 and `res_ovf`=0.
  - After the sample, ISSUE→IDLE and `res_valid`=1 for exactly one cycle.
- Operands are read at acceptance. `rs1`/`rs2` equal to the in-flight `rd` therefore read the old value, but a back-to-back instruction accepted in the result cycle sees the new value: the write lands on the same edge that enters IDLE.
- `rd`=`rs1`=`rs2` is legal.
- All register indices, including r0, are general-purpose; there is no hardwired zero.
- The controller does not interpret ALU semantics. The overflow flag and MULT result format are whatever the ALU returns.
- `ovf_sticky`:
  - sets when `res_valid` && `res_ovf`;
  - `ovf_clr` clears it;
  - a set and a clear in the same cycle leave it set.
- `dbg_data` reads the register array combinationally. A read of an address being written in the current cycle returns the old value.

## Timing
- Latency: an instruction accepted at edge E0 has its ALU inputs valid in cycle E0..E1. The result is written at E1, with `res_valid`, `res_*` and the new register value visible in cycle E1..E2.
- Throughput is one instruction per 2 cycles; `in_ready` returns to 1 in the same cycle that `res_valid` is high.
- Reset values: FSM=IDLE, `in_ready`=1. The following are all 0:
  - `alu_src1`, `alu_src2`, `alu_opcode`;
  - `res_valid`, `res_rd`, `res_data`, `res_ovf`, `ovf_sticky`;
  - all registers.
- Reset mid-operation (during ISSUE):
  - the in-flight instruction is dropped;
  - no register write occurs;
  - no `res_valid` is produced;
  - the next cycle is IDLE.
- `rst` has priority over every other input, including `ovf_clr`.

## Structure
- Shared package `alu_pkg` holds:
  - `DATA_W` and `OP_W`=3;
  - opcode constants `OP_ADD`…`OP_MULT`, `OP_LOADI`, `OP_NOP`;
  - the FSM state enum `{S_IDLE, S_ISSUE}`.
- One sub-module, `alu_regfile`: 2 async read ports plus 1 debug read port, 1 sync write port, synchronous reset to 0.
- The `alu` instance is not inside this block. The system top connects the `alu_*` ports to it, and the bench instantiates both.

## Test plan
- Load and add: LOADI r1=50, LOADI r2=25, ADD r3=r1+r2. Required:
  - `res_valid` exactly 2 cycles after each acceptance;
  - final `res_data`=75, `res_ovf`=0;
  - `dbg_addr`=3 reads back 75.
- Overflow sticky: LOADI r1=65536, LOADI r2=1, ADD r4=r1+r2. Required:
  - `res_data`=1, `res_ovf`=1, `ovf_sticky`=1;
  - a following SUB with no overflow leaves `ovf_sticky`=1;
  - pulsing `ovf_clr` drives it to 0.
- Backpressure: hold `in_valid`=1 with 3 queued instructions. Required: each is accepted only when `in_ready`=1; the acceptances are 2 cycles apart, and none is lost or duplicated.
- Same-register dependency: r1=100, then SUB r1=r1−r1. Required: `res_data`=0; an immediately following ADD r2=r1+r1 gives `res_data`=0.
- Logic ops and NOP: for AND, OR and XOR, r1=0x15555 and r2=0x1E1E1, writing r5, r6 and r7. Required:
  - results 0x14141, 0x1F5F5 and 0x0B4B4;
  - NOP pulses `res_valid` with no register change.
- Reset mid-operation: assert `rst` in the ISSUE cycle of ADD r3. Required: r3 stays 0, no `res_valid`, `in_ready`=1 the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execution controller.
package alu_pkg;

   localparam int unsigned DATA_W = 17;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
   localparam logic [OP_W-1:0] OP_AND   = 3'b010;
   localparam logic [OP_W-1:0] OP_OR    = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR   = 3'b100;
   localparam logic [OP_W-1:0] OP_MULT  = 3'b101;
   localparam logic [OP_W-1:0] OP_LOADI = 3'b110;
   localparam logic [OP_W-1:0] OP_NOP   = 3'b111;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async operand reads, one async debug read, one sync write.
module alu_regfile #(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned NREGS  = 8,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic [AW-1:0]     raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic [AW-1:0]     dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Reads see the stored value, so a same-cycle write is not forwarded.
   assign rdata1_o   = regs_q[raddr1_i];
   assign rdata2_o   = regs_q[raddr2_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

   // Next-state: apply the single write port.
   always_comb begin
      regs_d = regs_q;
      if (we_i) begin
         regs_d[waddr_i] = wdata_i;
      end
   end

   // Array state with synchronous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Two-cycle execution controller feeding an external ALU from a register file.
module alu_exec_ctrl #(
   parameter int unsigned DATA_W = 17,
   parameter int unsigned NREGS  = 8,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [AW-1:0]     in_rd,
   input  logic [AW-1:0]     in_rs1,
   input  logic [AW-1:0]     in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   output logic [2:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_dest,
   input  logic              alu_ovf,
   output logic              res_valid,
   output logic [AW-1:0]     res_rd,
   output logic [DATA_W-1:0] res_data,
   output logic              res_ovf,
   output logic              ovf_sticky,
   input  logic              ovf_clr,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   import alu_pkg::*;

   state_e            state_q, state_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
   logic [2:0]        opcode_q, opcode_d;
   logic              res_valid_q, res_valid_d;
   logic [AW-1:0]     res_rd_q, res_rd_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_ovf_q, res_ovf_d;
   logic              sticky_q, sticky_d;

   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata, rf_rdata1, rf_rdata2;
   logic              accept;

   alu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (rf_wdata),
      .raddr1_i   (in_rs1),
      .rdata1_o   (rf_rdata1),
      .raddr2_i   (in_rs2),
      .rdata2_o   (rf_rdata2),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data)
   );

   assign in_ready   = (state_q == S_IDLE);
   assign accept     = in_valid && in_ready;
   assign alu_src1   = src1_q;
   assign alu_src2   = src2_q;
   assign alu_opcode = opcode_q;
   assign res_valid  = res_valid_q;
   assign res_rd     = res_rd_q;
   assign res_data   = res_data_q;
   assign res_ovf    = res_ovf_q;
   assign ovf_sticky = sticky_q;

   // Next-state: latch on acceptance, retire and write back on the ISSUE edge.
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      opcode_d    = opcode_q;
      res_valid_d = 1'b0;
      res_rd_d    = res_rd_q;
      res_data_d  = res_data_q;
      res_ovf_d   = res_ovf_q;
      rf_we       = 1'b0;
      rf_wdata    = '0;

      if (accept) begin
         state_d  = S_ISSUE;
         rd_d     = in_rd;
         imm_d    = in_imm;
         src1_d   = rf_rdata1;
         src2_d   = rf_rdata2;
         opcode_d = in_op;
      end

      if (state_q == S_ISSUE) begin
         state_d     = S_IDLE;
         res_valid_d = 1'b1;
         res_rd_d    = rd_q;
         unique case (opcode_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MULT: begin
               rf_we     = 1'b1;
               rf_wdata  = alu_dest;
               res_ovf_d = alu_ovf;
            end
            OP_LOADI: begin
               rf_we     = 1'b1;
               rf_wdata  = imm_q;
               res_ovf_d = 1'b0;
            end
            OP_NOP: begin
               res_ovf_d = 1'b0;
            end
         endcase
         res_data_d = rf_wdata;
      end

      // Set wins over a simultaneous clear.
      sticky_d = sticky_q;
      if (ovf_clr) begin
         sticky_d = 1'b0;
      end
      if (res_valid_q && res_ovf_q) begin
         sticky_d = 1'b1;
      end
   end

   // Controller state with synchronous reset taking priority over all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rd_q        <= '0;
         imm_q       <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         opcode_q    <= '0;
         res_valid_q <= 1'b0;
         res_rd_q    <= '0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         opcode_q    <= opcode_d;
         res_valid_q <= res_valid_d;
         res_rd_q    <= res_rd_d;
         res_data_q  <= res_data_d;
         res_ovf_q   <= res_ovf_d;
         sticky_q    <= sticky_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small stand-in ALU.
module tb_alu_exec_ctrl;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, MULT = 3'b101, LDI = 3'b110, NOP = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'b111;
   logic [2:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [16:0] in_imm = '0;
   logic [16:0] alu_src1, alu_src2, alu_dest;
   logic [2:0]  alu_opcode;
   logic        alu_ovf;
   logic        res_valid;
   logic [2:0]  res_rd;
   logic [16:0] res_data;
   logic        res_ovf;
   logic        ovf_sticky;
   logic        ovf_clr = 1'b0;
   logic [2:0]  dbg_addr = '0;
   logic [16:0] dbg_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_exec_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_imm     (in_imm),
      .alu_src1   (alu_src1),
      .alu_src2   (alu_src2),
      .alu_opcode (alu_opcode),
      .alu_dest   (alu_dest),
      .alu_ovf    (alu_ovf),
      .res_valid  (res_valid),
      .res_rd     (res_rd),
      .res_data   (res_data),
      .res_ovf    (res_ovf),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // Stand-in ALU: arithmetic keeps 16 bits and flags a carry into bit 16.
   // LOADI returns junk so that the controller is seen to ignore it.
   logic [16:0] sum;
   always_comb begin
      sum      = '0;
      alu_dest = '0;
      alu_ovf  = 1'b0;
      case (alu_opcode)
         ADD:  begin sum = alu_src1 + alu_src2; alu_dest = {1'b0, sum[15:0]}; alu_ovf = sum[16]; end
         SUB:  begin sum = alu_src1 - alu_src2; alu_dest = {1'b0, sum[15:0]}; alu_ovf = sum[16]; end
         AND_: alu_dest = alu_src1 & alu_src2;
         OR_:  alu_dest = alu_src1 | alu_src2;
         XOR_: alu_dest = alu_src1 ^ alu_src2;
         MULT: begin sum = alu_src1 * alu_src2; alu_dest = {1'b0, sum[15:0]}; end
         LDI:  begin alu_dest = 17'h1ABCD; alu_ovf = 1'b1; end
         default: ;
      endcase
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic dbg_chk(input logic [2:0] a, input logic [16:0] exp, input string tag);
      dbg_addr = a;
      #1;
      chk(32'(dbg_data), 32'(exp), tag);
   endtask

   // Entered just after a negedge with the controller idle; returns at the
   // negedge inside the result cycle, so calls chain back to back.
   task automatic exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [16:0] imm,
                       input logic [16:0] e_s1, input logic [16:0] e_s2,
                       input logic [16:0] e_data, input logic e_ovf, input string tag);
      in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      chk(32'(in_ready), 32'd1, {tag, ".ready"});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk(32'(in_ready),   32'd0,       {tag, ".busy"});
      chk(32'(res_valid),  32'd0,       {tag, ".early"});
      chk(32'(alu_opcode), 32'(op),     {tag, ".opc"});
      chk(32'(alu_src1),   32'(e_s1),   {tag, ".src1"});
      chk(32'(alu_src2),   32'(e_s2),   {tag, ".src2"});
      @(negedge clk);
      chk(32'(res_valid),  32'd1,       {tag, ".rvalid"});
      chk(32'(res_rd),     32'(rd),     {tag, ".rd"});
      chk(32'(res_data),   32'(e_data), {tag, ".data"});
      chk(32'(res_ovf),    32'(e_ovf),  {tag, ".ovf"});
      chk(32'(in_ready),   32'd1,       {tag, ".ready2"});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      int          n_acc, n_res, guard, extra;
      int          acc_t [3];
      logic [16:0] res_seen [3];
      logic        rdy;
      logic [2:0]  bp_op [3];
      logic [2:0]  bp_rd [3];
      logic [16:0] bp_imm [3];

      // Reset values
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk(32'(in_ready),   32'd1, "rst.ready");
      chk(32'(alu_src1),   32'd0, "rst.src1");
      chk(32'(alu_src2),   32'd0, "rst.src2");
      chk(32'(alu_opcode), 32'd0, "rst.opc");
      chk(32'(res_valid),  32'd0, "rst.rvalid");
      chk(32'(res_rd),     32'd0, "rst.rd");
      chk(32'(res_data),   32'd0, "rst.data");
      chk(32'(res_ovf),    32'd0, "rst.ovf");
      chk(32'(ovf_sticky), 32'd0, "rst.sticky");
      for (int i = 0; i < 8; i++) dbg_chk(3'(i), 17'd0, "rst.reg");

      // Load and add
      exec(LDI, 3'd1, 3'd0, 3'd0, 17'd50, 17'd0,  17'd0,  17'd50, 1'b0, "ld1");
      exec(LDI, 3'd2, 3'd0, 3'd0, 17'd25, 17'd0,  17'd0,  17'd25, 1'b0, "ld2");
      exec(ADD, 3'd3, 3'd1, 3'd2, 17'd0,  17'd50, 17'd25, 17'd75, 1'b0, "add");
      dbg_chk(3'd3, 17'd75, "add.dbg");

      // Overflow and sticky flag, including set-and-clear in one cycle
      exec(LDI, 3'd1, 3'd0, 3'd0, 17'd65536, 17'd0, 17'd0, 17'd65536, 1'b0, "ovf.ld1");
      exec(LDI, 3'd2, 3'd0, 3'd0, 17'd1, 17'd0, 17'd0, 17'd1, 1'b0, "ovf.ld2");
      exec(ADD, 3'd4, 3'd1, 3'd2, 17'd0, 17'd65536, 17'd1, 17'd1, 1'b1, "ovf.add");
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk(32'(ovf_sticky), 32'd1, "ovf.setclr");
      exec(SUB, 3'd5, 3'd2, 3'd2, 17'd0, 17'd1, 17'd1, 17'd0, 1'b0, "ovf.sub");
      @(negedge clk);
      chk(32'(ovf_sticky), 32'd1, "ovf.hold");
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk(32'(ovf_sticky), 32'd0, "ovf.clr");

      // Same-register dependency, then back-to-back read of the new value
      exec(LDI, 3'd1, 3'd0, 3'd0, 17'd100, 17'd0, 17'd0, 17'd100, 1'b0, "dep.ld");
      exec(SUB, 3'd1, 3'd1, 3'd1, 17'd0, 17'd100, 17'd100, 17'd0, 1'b0, "dep.sub");
      exec(ADD, 3'd2, 3'd1, 3'd1, 17'd0, 17'd0, 17'd0, 17'd0, 1'b0, "dep.add");

      // Logic ops and NOP
      exec(LDI, 3'd1, 3'd0, 3'd0, 17'h15555, 17'd0, 17'd0, 17'h15555, 1'b0, "lg.ld1");
      exec(LDI, 3'd2, 3'd0, 3'd0, 17'h1E1E1, 17'd0, 17'd0, 17'h1E1E1, 1'b0, "lg.ld2");
      exec(AND_, 3'd5, 3'd1, 3'd2, 17'd0, 17'h15555, 17'h1E1E1, 17'h14141, 1'b0, "lg.and");
      exec(OR_,  3'd6, 3'd1, 3'd2, 17'd0, 17'h15555, 17'h1E1E1, 17'h1F5F5, 1'b0, "lg.or");
      exec(XOR_, 3'd7, 3'd1, 3'd2, 17'd0, 17'h15555, 17'h1E1E1, 17'h0B4B4, 1'b0, "lg.xor");
      exec(NOP,  3'd5, 3'd1, 3'd2, 17'd0, 17'h15555, 17'h1E1E1, 17'd0, 1'b0, "lg.nop");
      dbg_chk(3'd5, 17'h14141, "nop.r5");
      dbg_chk(3'd6, 17'h1F5F5, "lg.r6");
      dbg_chk(3'd7, 17'h0B4B4, "lg.r7");

      // Backpressure: in_valid held high across three queued instructions
      bp_op[0] = LDI; bp_rd[0] = 3'd1; bp_imm[0] = 17'd7;
      bp_op[1] = LDI; bp_rd[1] = 3'd2; bp_imm[1] = 17'd9;
      bp_op[2] = ADD; bp_rd[2] = 3'd3; bp_imm[2] = 17'd0;
      in_rs1 = 3'd1; in_rs2 = 3'd2;
      in_op = bp_op[0]; in_rd = bp_rd[0]; in_imm = bp_imm[0];
      in_valid = 1'b1;
      n_acc = 0; n_res = 0; guard = 0;
      while ((n_acc < 3 || n_res < 3) && guard < 30) begin
         rdy = in_ready;
         @(posedge clk);
         guard++;
         if (rdy && in_valid) begin
            acc_t[n_acc] = guard;
            n_acc++;
            #1;
            if (n_acc < 3) begin
               in_op = bp_op[n_acc]; in_rd = bp_rd[n_acc]; in_imm = bp_imm[n_acc];
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (res_valid) begin
            if (n_res < 3) res_seen[n_res] = res_data;
            n_res++;
         end
      end
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (res_valid) extra++;
      end
      chk(32'(n_acc), 32'd3, "bp.nacc");
      chk(32'(n_res), 32'd3, "bp.nres");
      chk(32'(extra), 32'd0, "bp.extra");
      chk(32'(acc_t[1] - acc_t[0]), 32'd2, "bp.gap1");
      chk(32'(acc_t[2] - acc_t[1]), 32'd2, "bp.gap2");
      chk(32'(res_seen[0]), 32'd7,  "bp.r0");
      chk(32'(res_seen[1]), 32'd9,  "bp.r1");
      chk(32'(res_seen[2]), 32'd16, "bp.r2");
      dbg_chk(3'd3, 17'd16, "bp.dbg");

      // Reset during the ISSUE cycle of ADD r3
      in_op = ADD; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk(32'(in_ready), 32'd0, "mid.busy");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(32'(res_valid), 32'd0, "mid.rvalid");
      chk(32'(in_ready),  32'd1, "mid.ready");
      dbg_chk(3'd3, 17'd0, "mid.r3");
      @(negedge clk);
      chk(32'(res_valid), 32'd0, "mid.rvalid2");

      // Recovery after reset
      exec(LDI, 3'd1, 3'd0, 3'd0, 17'd3, 17'd0, 17'd0, 17'd3, 1'b0, "rec.ld");
      exec(ADD, 3'd3, 3'd1, 3'd1, 17'd0, 17'd3, 17'd3, 17'd6, 1'b0, "rec.add");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
